// File: rtl/misr_signature_engine.sv
`default_nettype none
// ============================================================================
// Module      : misr_signature_engine
// Description : Multiple-input signature register (Galois LFSR) that compacts
//               M parallel response bits per cycle into an N-bit signature,
//               counts a programmable number of compaction cycles and compares
//               the final signature against a golden value.
//               Optional X-masking of response bits: define MISR_XMASK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module misr_signature_engine #(
    parameter int N  = 8,
    parameter int M  = 4,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          en,
    input  logic [N-1:0]  poly,
    input  logic [N-1:0]  seed,
    input  logic [M-1:0]  din,
`ifdef MISR_XMASK_EN
    input  logic [M-1:0]  din_mask,
    output logic [CW-1:0] masked_cnt,
`endif
    input  logic [CW-1:0] num_cycles,
    input  logic [N-1:0]  golden,
    output logic [N-1:0]  signature,
    output logic          busy,
    output logic          done,
    output logic          pass
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [N-1:0]  r_sig;
    logic [CW-1:0] r_count;
    logic          r_pass;
    logic [N-1:0]  w_next;
    logic [N-1:0]  w_inj;
    logic [M-1:0]  w_din_eff;
    logic [CW-1:0] w_last_cnt;
    logic          w_last;
    logic          w_step;
    logic          w_zero_len;
    logic          w_unused_poly_msb;

    // The top tap is implied by the feedback into stage N-1.
    assign w_unused_poly_msb = poly[N-1];

`ifdef MISR_XMASK_EN
    logic [CW-1:0] r_masked_cnt;

    assign w_din_eff = din & ~din_mask;
`else
    assign w_din_eff = din;
`endif

    // Response bit j enters stage N-1-j, so din[0] always lands in the MSB.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_inj_bit
            if (gi >= N - M) begin : g_din
                assign w_inj[gi] = w_din_eff[N-1-gi];
            end else begin : g_zero
                assign w_inj[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        w_next      = '0;
        w_next[N-1] = r_sig[0] ^ w_inj[N-1];
        for (int i = 0; i < N - 1; i++) begin
            w_next[i] = (r_sig[0] & poly[i]) ^ r_sig[i+1] ^ w_inj[i];
        end
    end

    assign w_last_cnt = num_cycles - CW'(1);
    assign w_last     = (r_count == w_last_cnt);
    assign w_step     = (r_state == c_ST_RUN) && en && !start;
    assign w_zero_len = (num_cycles == '0);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic; start restarts from any state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = w_zero_len ? c_ST_DONE : c_ST_RUN;
        end else begin
            case (r_state)
                c_ST_IDLE: w_state_nxt = c_ST_IDLE;
                c_ST_RUN:  w_state_nxt = (en && w_last) ? c_ST_DONE : c_ST_RUN;
                c_ST_DONE: w_state_nxt = c_ST_DONE;
                default:   w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sig   <= '0;
            r_count <= '0;
            r_pass  <= 1'b0;
        end else if (start) begin
            r_sig   <= seed;
            r_count <= '0;
            r_pass  <= w_zero_len && (seed == golden);
        end else if (w_step) begin
            r_sig <= w_next;
            // Holding on the last cycle keeps count within num_cycles-1.
            if (!w_last) begin
                r_count <= r_count + CW'(1);
            end
            r_pass <= w_last && (w_next == golden);
        end
    end

`ifdef MISR_XMASK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_masked_cnt <= '0;
        end else if (start) begin
            r_masked_cnt <= '0;
        end else if (w_step && (|din_mask)) begin
            r_masked_cnt <= r_masked_cnt + CW'(1);
        end
    end

    assign masked_cnt = r_masked_cnt;
`endif

    // ------------------------------------------------------------------
    // FSM: outputs, decoded from registered state only
    // ------------------------------------------------------------------
    always_comb begin
        busy      = (r_state == c_ST_RUN);
        done      = (r_state == c_ST_DONE);
        pass      = r_pass && (r_state == c_ST_DONE);
        signature = r_sig;
    end

endmodule
`default_nettype wire

// File: tb/tb_misr_signature_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_misr_signature_engine
// Description : Self-checking scoreboard bench for misr_signature_engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_misr_signature_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        en;
    logic [7:0]  poly;
    logic [7:0]  seed;
    logic [3:0]  din;
    logic [15:0] num_cycles;
    logic [7:0]  golden;
    logic [7:0]  signature;
    logic        busy;
    logic        done;
    logic        pass;
`ifdef MISR_XMASK_EN
    logic [3:0]  din_mask;
    logic [15:0] masked_cnt;
`endif

    typedef struct {
        logic [7:0] sig;
        logic       pass;
        int         mcnt;
    } exp_t;

    exp_t       r_sb[$];
    logic [3:0] stim_din[$];
    logic [3:0] stim_mask[$];
    bit         stim_en[$];
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    misr_signature_engine #(.N(8), .M(4), .CW(16)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .en         (en),
        .poly       (poly),
        .seed       (seed),
        .din        (din),
`ifdef MISR_XMASK_EN
        .din_mask   (din_mask),
        .masked_cnt (masked_cnt),
`endif
        .num_cycles (num_cycles),
        .golden     (golden),
        .signature  (signature),
        .busy       (busy),
        .done       (done),
        .pass       (pass)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shift right, fold tapped feedback, then XOR din bit-reversed into the top.
    function automatic logic [7:0] misr_model(input logic [7:0] s, input logic [3:0] d,
                                              input logic [7:0] p);
        logic [7:0] t;
        t = {s[0], s[7:1]};
        if (s[0]) t[6:0] = t[6:0] ^ p[6:0];
        for (int j = 0; j < 4; j++) t[7-j] = t[7-j] ^ d[j];
        return t;
    endfunction

    task automatic clear_stim();
        stim_din.delete();
        stim_en.delete();
        stim_mask.delete();
    endtask

    task automatic add_stim(input bit e, input logic [3:0] d, input logic [3:0] m);
        stim_en.push_back(e);
        stim_din.push_back(d);
        stim_mask.push_back(m);
    endtask

    // stop_after >= 0 abandons the session after that many enabled cycles.
    task automatic run_session(input string tag, input logic [7:0] s_seed,
                               input logic [7:0] s_poly, input logic [7:0] s_gold,
                               input logic [15:0] ncyc, input int stop_after);
        exp_t       e;
        int         idx;
        int         cnt;
        int         mcnt;
        logic [7:0] msig;
        logic [3:0] w;
        seed       = s_seed;
        poly       = s_poly;
        golden     = s_gold;
        num_cycles = ncyc;
        din        = 4'($urandom);
        en         = 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        msig  = s_seed;
        cnt   = 0;
        idx   = 0;
        mcnt  = 0;
        check({tag, "_start_sig"}, 32'(signature), 32'(s_seed));
        check({tag, "_start_busy"}, 32'(busy), 32'(ncyc != 0));
        if (ncyc == 0) begin
            e.sig = s_seed; e.pass = (s_seed == s_gold); e.mcnt = 0;
            r_sb.push_back(e);
        end
        while (cnt < int'(ncyc) && cnt != stop_after) begin
            if (idx >= stim_en.size()) begin
                check({tag, "_stim_budget"}, 32'(idx), 32'(stim_en.size() + 1));
                break;
            end
            en  = stim_en[idx];
            din = stim_din[idx];
`ifdef MISR_XMASK_EN
            din_mask = stim_mask[idx];
            w = din & ~din_mask;
            if (en && (|din_mask)) mcnt++;
`else
            w = din;
`endif
            if (en) begin
                msig = misr_model(msig, w, s_poly);
                cnt++;
                if (cnt == int'(ncyc)) begin
                    e.sig = msig; e.pass = (msig == s_gold); e.mcnt = mcnt;
                    r_sb.push_back(e);
                end
            end
            idx++;
            tick();
            check({tag, "_sig"}, 32'(signature), 32'(msig));
            check({tag, "_done"}, 32'(done), 32'(cnt == int'(ncyc)));
        end
        en = 1'b0;
`ifdef MISR_XMASK_EN
        din_mask = 4'h0;
`endif
        if (cnt == int'(ncyc)) begin
            if (r_sb.size() == 0) begin
                check({tag, "_sb_empty"}, 32'(0), 32'(1));
            end else begin
                e = r_sb.pop_front();
                check({tag, "_final_sig"}, 32'(signature), 32'(e.sig));
                check({tag, "_final_pass"}, 32'(pass), 32'(e.pass));
                check({tag, "_final_done"}, 32'(done), 32'(1));
                check({tag, "_final_busy"}, 32'(busy), 32'(0));
`ifdef MISR_XMASK_EN
                check({tag, "_masked_cnt"}, 32'(masked_cnt), 32'(e.mcnt));
`endif
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; en = 1'b0; poly = '0; seed = '0;
        din = '0; num_cycles = '0; golden = '0;
`ifdef MISR_XMASK_EN
        din_mask = '0;
`endif
        tick();
        tick();
        check("rst_sig", 32'(signature), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_pass", 32'(pass), 32'(0));
        rst = 1'b0;
        tick();

        // Rotation with no taps and no input: returns to the seed after 8 steps
        clear_stim();
        for (int i = 0; i < 8; i++) add_stim(1'b1, 4'h0, 4'h0);
        run_session("rot_pass", 8'h01, 8'h00, 8'h01, 16'd8, -1);
        check("rot_const_sig", 32'(signature), 32'h01);
        check("rot_const_pass", 32'(pass), 32'd1);
        run_session("rot_fail", 8'h01, 8'h00, 8'h02, 16'd8, -1);
        check("rot_fail_const_pass", 32'(pass), 32'd0);

        // Single cycle, four-bit injection
        clear_stim();
        add_stim(1'b1, 4'b0011, 4'h0);
        run_session("inj1", 8'h00, 8'h00, 8'h00, 16'd1, -1);
        check("inj1_const_sig", 32'(signature), 32'hC0);

        // Zero-length session
        run_session("zero", 8'hA5, 8'h1D, 8'hA5, 16'd0, -1);
        check("zero_const_pass", 32'(pass), 32'd1);

        // en gaps hold the signature
        clear_stim();
        for (int i = 0; i < 7; i++) add_stim(bit'(i % 2 == 0), 4'($urandom), 4'h0);
        run_session("en_gap", 8'h3C, 8'h1D, 8'h00, 16'd4, -1);

        // Restart mid-session, then an uninterrupted session from the same seed
        clear_stim();
        for (int i = 0; i < 8; i++) add_stim(1'b1, 4'($urandom), 4'h0);
        run_session("restart_a", 8'h5A, 8'hB8, 8'h00, 16'd8, 3);
        run_session("restart_b", 8'h5A, 8'hB8, 8'h00, 16'd8, -1);

        // Reset mid-session
        run_session("rst_mid", 8'h77, 8'h1D, 8'h00, 16'd8, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_sig", 32'(signature), 32'(0));
        check("rst_mid_busy", 32'(busy), 32'(0));
        check("rst_mid_done", 32'(done), 32'(0));
        check("rst_mid_pass", 32'(pass), 32'(0));
        tick();
        check("rst_mid_idle_busy", 32'(busy), 32'(0));
        check("rst_mid_idle_done", 32'(done), 32'(0));

        // Random sessions with random taps and en patterns
        for (int k = 0; k < 6; k++) begin
            clear_stim();
            for (int i = 0; i < 60; i++) add_stim(bit'((i % 2 == 0) || ($urandom_range(0, 1) == 1)),
                                                  4'($urandom), 4'h0);
            run_session("rand", 8'($urandom), 8'($urandom), 8'($urandom),
                        16'($urandom_range(1, 20)), -1);
        end

`ifdef MISR_XMASK_EN
        // X-masking on two of four cycles
        clear_stim();
        add_stim(1'b1, 4'hF, 4'hF);
        add_stim(1'b1, 4'hF, 4'h0);
        add_stim(1'b1, 4'hF, 4'hF);
        add_stim(1'b1, 4'hF, 4'h0);
        run_session("xmask", 8'h81, 8'h1D, 8'h00, 16'd4, -1);
        check("xmask_const_cnt", 32'(masked_cnt), 32'd2);
`endif

        check("sb_drained", 32'(r_sb.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
